// File: rtl/alarm_clock_multi_pkg.sv
// Shared constants, channel state encoding and hour/minute helpers for the
// multi-alarm clock.
package alarm_clock_pkg;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;

  typedef enum logic [1:0] {CH_IDLE, CH_RING, CH_SNOOZE} ch_state_e;

  function automatic logic [HR_W-1:0] to_disp_hr(input logic [HR_W-1:0] hr, input logic fmt24);
    if (fmt24)           return hr;
    if (hr == '0)        return 5'd12;
    if (hr > 5'd12)      return hr - 5'd12;
    return hr;
  endfunction

  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
    return (m == MIN_W'(MIN_MAX)) ? '0 : m + 6'd1;
  endfunction

  function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] h);
    return (h == HR_W'(HR_MAX)) ? '0 : h + 5'd1;
  endfunction
endpackage

// File: rtl/alarm_clock_multi_if.sv
// Control/status bundle between the board logic and the multi-alarm clock.
interface alarm_clock_multi_if import alarm_clock_pkg::*; #(
  parameter int NUM_ALARMS = 4
);
  localparam int SEL_W = $clog2(NUM_ALARMS + 1);

  logic [SEL_W-1:0]      set_sel;
  logic                  set_hr;
  logic                  set_min;
  logic                  fmt24;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic [NUM_ALARMS-1:0] snooze;
  logic [NUM_ALARMS-1:0] dismiss;
  logic [HR_W-1:0]       hr_out;
  logic                  pm_out;
  logic [MIN_W-1:0]      min_out;
  logic [MIN_W-1:0]      sec_out;
  logic [HR_W-1:0]       alm_hr_out;
  logic [MIN_W-1:0]      alm_min_out;
  logic [NUM_ALARMS-1:0] alarm_active;
  logic                  alarm_any;

  modport master (
    output set_sel, set_hr, set_min, fmt24, alarm_en, snooze, dismiss,
    input  hr_out, pm_out, min_out, sec_out, alm_hr_out, alm_min_out, alarm_active, alarm_any
  );

  modport slave (
    input  set_sel, set_hr, set_min, fmt24, alarm_en, snooze, dismiss,
    output hr_out, pm_out, min_out, sec_out, alm_hr_out, alm_min_out, alarm_active, alarm_any
  );
endinterface

// File: rtl/alarm_clock_multi_channel.sv
// One alarm channel: alarm time registers, edge-triggered match, and the
// idle/ring/snooze state with its snooze and ring-timeout counters.
module alarm_channel import alarm_clock_pkg::*; #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hr_inc,
  input  logic             min_inc,
  input  logic             sec_tick,
  input  logic             min_roll,
  input  logic             dismiss,
  input  logic             snooze,
  input  logic [HR_W-1:0]  hr_nxt,
  input  logic [MIN_W-1:0] min_nxt,
  output logic [HR_W-1:0]  alm_hr,
  output logic [MIN_W-1:0] alm_min,
  output logic             active,
  output logic             active_nxt
);
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  ch_state_e   state, state_n;
  logic [5:0]  snz_cnt, snz_cnt_n;
  logic [7:0]  ring_cnt, ring_cnt_n;
  logic        match;

  // Only a minute rollover into hh:mm:00 can fire; editing the alarm never does.
  assign match      = min_roll && (hr_nxt == alm_hr) && (min_nxt == alm_min);
  assign active     = (state == CH_RING);
  assign active_nxt = (state_n == CH_RING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm_hr  <= '0;
      alm_min <= '0;
    end else begin
      if (hr_inc)  alm_hr  <= inc_hr(alm_hr);
      if (min_inc) alm_min <= inc_min(alm_min);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      snz_cnt  <= '0;
      ring_cnt <= '0;
    end else begin
      state    <= state_n;
      snz_cnt  <= snz_cnt_n;
      ring_cnt <= ring_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    snz_cnt_n  = snz_cnt;
    ring_cnt_n = ring_cnt;
    if (!en || dismiss) begin
      state_n   = CH_IDLE;
      snz_cnt_n = '0;
    end else if (match && state != CH_RING) begin
      state_n    = CH_RING;
      snz_cnt_n  = '0;
      ring_cnt_n = '0;
    end else begin
      case (state)
        CH_RING: begin
          if (snooze) begin
            state_n   = CH_SNOOZE;
            snz_cnt_n = 6'(SNOOZE_MIN);
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) state_n = CH_IDLE;
            else                       ring_cnt_n = ring_cnt + 8'd1;
          end
        end
        CH_SNOOZE: begin
          if (min_roll) begin
            if (snz_cnt == 6'd1) begin
              state_n    = CH_RING;
              snz_cnt_n  = '0;
              ring_cnt_n = '0;
            end else begin
              snz_cnt_n = snz_cnt - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/alarm_clock_multi.sv
// Multi-alarm clock: prescaler, 24 h time counters, set-edge detect,
// alarm readback mux and the per-channel alarm array.
module alarm_clock_multi import alarm_clock_pkg::*; #(
  parameter int NUM_ALARMS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic                clk,
  input  logic                rst,
  alarm_clock_multi_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_ALARMS + 1);
  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]                  presc;
  logic [MIN_W-1:0]                  sec, sec_n, min, min_n;
  logic [HR_W-1:0]                   hr, hr_n;
  logic                              set_hr_q, set_min_q, hr_pulse, min_pulse;
  logic                              sec_tick, min_roll, hr_carry, clk_sel;
  logic                              any_q;
  logic [NUM_ALARMS-1:0]             active, active_nxt;
  logic [NUM_ALARMS-1:0][HR_W-1:0]   alm_hr;
  logic [NUM_ALARMS-1:0][MIN_W-1:0]  alm_min;
  logic [HR_W-1:0]                   rd_hr;
  logic [MIN_W-1:0]                  rd_min;

  assign sec_tick  = (presc == PRE_W'(TICK_DIV - 1));
  assign hr_pulse  = bus.set_hr & ~set_hr_q;
  assign min_pulse = bus.set_min & ~set_min_q;
  assign clk_sel   = (bus.set_sel == '0);
  assign min_roll  = sec_tick && (sec == MIN_W'(SEC_MAX));
  // A minute set in the same cycle swallows the carry it would have produced.
  assign hr_carry  = min_roll && (min == MIN_W'(MIN_MAX)) && !(clk_sel && min_pulse);

  always_comb begin
    sec_n = sec;
    min_n = min;
    hr_n  = hr;
    if (sec_tick) sec_n = min_roll ? '0 : sec + 6'd1;
    if ((clk_sel && min_pulse) || min_roll) min_n = inc_min(min);
    if ((clk_sel && hr_pulse) || hr_carry)  hr_n  = inc_hr(hr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      sec       <= '0;
      min       <= '0;
      hr        <= '0;
      set_hr_q  <= 1'b0;
      set_min_q <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      presc     <= sec_tick ? '0 : presc + PRE_W'(1);
      sec       <= sec_n;
      min       <= min_n;
      hr        <= hr_n;
      set_hr_q  <= bus.set_hr;
      set_min_q <= bus.set_min;
      any_q     <= |active_nxt;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_SECS  (RING_SECS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (bus.alarm_en[i]),
      .hr_inc     (hr_pulse  && (bus.set_sel == SEL_W'(i + 1))),
      .min_inc    (min_pulse && (bus.set_sel == SEL_W'(i + 1))),
      .sec_tick   (sec_tick),
      .min_roll   (min_roll),
      .dismiss    (bus.dismiss[i]),
      .snooze     (bus.snooze[i]),
      .hr_nxt     (hr_n),
      .min_nxt    (min_n),
      .alm_hr     (alm_hr[i]),
      .alm_min    (alm_min[i]),
      .active     (active[i]),
      .active_nxt (active_nxt[i])
    );
  end

  // Out-of-range selects fall back to channel 0, same as the clock target.
  always_comb begin
    rd_hr  = alm_hr[0];
    rd_min = alm_min[0];
    for (int i = 1; i < NUM_ALARMS; i++) begin
      if (bus.set_sel == SEL_W'(i + 1)) begin
        rd_hr  = alm_hr[i];
        rd_min = alm_min[i];
      end
    end
  end

  assign bus.hr_out       = to_disp_hr(hr, bus.fmt24);
  assign bus.pm_out       = (hr >= 5'd12);
  assign bus.min_out      = min;
  assign bus.sec_out      = sec;
  assign bus.alm_hr_out   = to_disp_hr(rd_hr, bus.fmt24);
  assign bus.alm_min_out  = rd_min;
  assign bus.alarm_active = active;
  assign bus.alarm_any    = any_q;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: seconds-of-day reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_alarm_clock_multi;
  localparam int NA = 4;
  localparam int TD = 4;
  localparam int SM = 5;
  localparam int RS = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_clock_multi_if #(.NUM_ALARMS(NA)) bus();

  alarm_clock_multi #(
    .NUM_ALARMS (NA),
    .TICK_DIV   (TD),
    .SNOOZE_MIN (SM),
    .RING_SECS  (RS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time as seconds of day, alarms as plain hour/minute,
  // ring/snooze as time remaining.
  int tod = 0, m_presc = 0;
  int ah[NA], am[NA], ring_left[NA], snz_left[NA];
  bit act[NA], pend[NA];
  bit p_hr = 0, p_min = 0;
  int h, m, s, base, nh, nm;
  bit tick, hp, mp, roll, csel, fire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tod = 0; m_presc = 0; p_hr = 0; p_min = 0;
      for (int i = 0; i < NA; i++) begin
        ah[i] = 0; am[i] = 0; act[i] = 0; pend[i] = 0; ring_left[i] = 0; snz_left[i] = 0;
      end
    end else begin
      tick    = (m_presc == TD - 1);
      m_presc = tick ? 0 : m_presc + 1;
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
      hp = bus.set_hr && !p_hr;  p_hr  = bus.set_hr;
      mp = bus.set_min && !p_min; p_min = bus.set_min;
      csel = (bus.set_sel == 0);
      base = tick ? (tod + 1) % 86400 : tod;
      nh = base / 3600; nm = (base / 60) % 60;
      if (csel && mp) begin nm = (m + 1) % 60; nh = h; end
      if (csel && hp) nh = (h + 1) % 24;
      roll = tick && (s == 59);
      tod  = nh * 3600 + nm * 60 + base % 60;
      for (int i = 0; i < NA; i++) begin
        fire = roll && bus.alarm_en[i] && !act[i] && nh == ah[i] && nm == am[i];
        if (!bus.alarm_en[i] || bus.dismiss[i]) begin
          act[i] = 0; pend[i] = 0;
        end else if (fire) begin
          act[i] = 1; pend[i] = 0; ring_left[i] = RS;
        end else if (act[i] && bus.snooze[i]) begin
          act[i] = 0; pend[i] = 1; snz_left[i] = SM;
        end else if (act[i] && tick) begin
          ring_left[i]--;
          if (ring_left[i] == 0) act[i] = 0;
        end else if (pend[i] && roll) begin
          snz_left[i]--;
          if (snz_left[i] == 0) begin act[i] = 1; pend[i] = 0; ring_left[i] = RS; end
        end
        if (bus.set_sel == i + 1) begin
          if (hp) ah[i] = (ah[i] + 1) % 24;
          if (mp) am[i] = (am[i] + 1) % 60;
        end
      end
    end
  end

  function automatic int disp(input int hh, input bit f24);
    return f24 ? hh : (hh + 11) % 12 + 1;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int idx, e_hr, e_min, e_sec, e_ahr, e_amin;
    bit e_pm;
    logic [NA-1:0] e_act;
    idx = (bus.set_sel >= 1 && bus.set_sel <= NA) ? int'(bus.set_sel) - 1 : 0;
    e_hr = disp(tod / 3600, bus.fmt24);
    e_pm = (tod / 3600) >= 12;
    e_min = (tod / 60) % 60;
    e_sec = tod % 60;
    e_ahr = disp(ah[idx], bus.fmt24);
    e_amin = am[idx];
    for (int i = 0; i < NA; i++) e_act[i] = act[i];
    n_chk++;
    if (bus.hr_out != e_hr || bus.pm_out != e_pm || bus.min_out != e_min ||
        bus.sec_out != e_sec || bus.alm_hr_out != e_ahr || bus.alm_min_out != e_amin ||
        bus.alarm_active != e_act || bus.alarm_any != (|e_act)) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got %0d:%0d:%0d pm%0d alm %0d:%0d act %b any %0d, expected %0d:%0d:%0d pm%0d alm %0d:%0d act %b any %0d",
               $time, bus.hr_out, bus.min_out, bus.sec_out, bus.pm_out, bus.alm_hr_out, bus.alm_min_out,
               bus.alarm_active, bus.alarm_any, e_hr, e_min, e_sec, e_pm, e_ahr, e_amin, e_act, |e_act);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk); #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) nc();
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin bus.set_hr = 1'b1; nc(); bus.set_hr = 1'b0; nc(); end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin bus.set_min = 1'b1; nc(); bus.set_min = 1'b0; nc(); end
  endtask

  initial begin
    rst = 1'b1;
    bus.set_sel = '0; bus.set_hr = 1'b0; bus.set_min = 1'b0; bus.fmt24 = 1'b1;
    bus.alarm_en = '0; bus.snooze = '0; bus.dismiss = '0;

    // Reset state in both formats
    wait_n(2);
    chk("rst_hr24", bus.hr_out, 0);
    bus.fmt24 = 1'b0; #1;
    chk("rst_hr12", bus.hr_out, 12);
    chk("rst_pm", bus.pm_out, 0);
    chk("rst_sec", bus.sec_out, 0);
    chk("rst_any", bus.alarm_any, 0);
    bus.fmt24 = 1'b1;
    rst = 1'b0;

    // One hour of free running
    wait_n(4 * 3600);
    chk("run_hr", bus.hr_out, 1);
    chk("run_min", bus.min_out, 0);
    chk("run_sec", bus.sec_out, 0);
    chk("run_pm", bus.pm_out, 0);

    // 23:59:59 -> midnight in 12 h format
    bus.fmt24 = 1'b0;
    press_hr(22); press_min(59); wait_n(74);
    chk("pre_mid_hr", bus.hr_out, 11);
    chk("pre_mid_pm", bus.pm_out, 1);
    chk("pre_mid_sec", bus.sec_out, 59);
    wait_n(4);
    chk("mid_hr", bus.hr_out, 12);
    chk("mid_pm", bus.pm_out, 0);
    chk("mid_min", bus.min_out, 0);

    // 11:59:59 -> noon
    press_hr(11); press_min(59); wait_n(96);
    chk("pre_noon_hr", bus.hr_out, 11);
    chk("pre_noon_pm", bus.pm_out, 0);
    wait_n(4);
    chk("noon_hr", bus.hr_out, 12);
    chk("noon_pm", bus.pm_out, 1);

    // Alarm 2 at 07:30, fire and ring timeout
    bus.alarm_en = 4'b0100;
    bus.set_sel = 3; press_hr(7); press_min(30);
    chk("alm2_hr", bus.alm_hr_out, 7);
    chk("alm2_min", bus.alm_min_out, 30);
    bus.set_sel = 0; press_hr(19); press_min(29);
    wait_n(69);
    chk("a2_pre_act", bus.alarm_active, 4'b0000);
    wait_n(1);
    chk("a2_fire_act", bus.alarm_active, 4'b0100);
    chk("a2_fire_any", bus.alarm_any, 1);
    wait_n(236);
    chk("a2_ring_last", bus.alarm_active, 4'b0100);
    wait_n(4);
    chk("a2_timeout", bus.alarm_active, 4'b0000);

    // Alarm 0 at 06:00: snooze, re-fire, then dismiss beats snooze
    bus.set_sel = 1; press_hr(6);
    bus.set_sel = 0; press_hr(22); press_min(28);
    bus.alarm_en = 4'b0101;
    wait_n(128);
    chk("a0_fire", bus.alarm_active, 4'b0001);
    bus.snooze = 4'b0001; nc(); bus.snooze = '0;
    chk("a0_snoozed", bus.alarm_active, 4'b0000);
    wait_n(1198);
    chk("a0_pre_refire", bus.alarm_active, 4'b0000);
    wait_n(1);
    chk("a0_refire", bus.alarm_active, 4'b0001);
    bus.snooze = 4'b0001; bus.dismiss = 4'b0001; nc();
    bus.snooze = '0; bus.dismiss = '0;
    chk("a0_dismiss", bus.alarm_active, 4'b0000);
    wait_n(1199);
    chk("a0_no_refire", bus.alarm_active, 4'b0000);

    // Minute set colliding with the :59 tick at 06:59:59
    bus.alarm_en = 4'b0100;
    press_min(49); wait_n(141);
    bus.set_min = 1'b1; nc(); bus.set_min = 1'b0;
    chk("coll_hr", bus.hr_out, 6);
    chk("coll_min", bus.min_out, 0);
    chk("coll_sec", bus.sec_out, 0);
    nc();
    bus.set_sel = 5; press_hr(1); press_min(1);
    chk("sel5_hr", bus.hr_out, 6);
    chk("sel5_min", bus.min_out, 0);
    chk("sel5_sec", bus.sec_out, 1);
    chk("sel5_alm_hr", bus.alm_hr_out, 6);
    chk("sel5_alm_min", bus.alm_min_out, 0);
    bus.set_sel = 4; #1;
    chk("alm3_hr", bus.alm_hr_out, 12);
    chk("alm3_min", bus.alm_min_out, 0);

    // Alarm 1 edited to current time, then disable and reset while ringing
    bus.set_sel = 2; bus.alarm_en = 4'b0110;
    press_hr(6); wait_n(40);
    chk("a1_no_fire", bus.alarm_active, 4'b0000);
    press_min(1); wait_n(181);
    chk("a1_fire", bus.alarm_active, 4'b0010);
    bus.alarm_en = 4'b0100; nc();
    chk("a1_disabled", bus.alarm_active, 4'b0000);
    press_min(1); bus.alarm_en = 4'b0110; wait_n(237);
    chk("a1_fire2", bus.alarm_active, 4'b0010);
    #2 rst = 1'b1; #1;
    chk("mrst_act", bus.alarm_active, 4'b0000);
    chk("mrst_any", bus.alarm_any, 0);
    chk("mrst_hr", bus.hr_out, 12);
    chk("mrst_min", bus.min_out, 0);
    chk("mrst_alm_hr", bus.alm_hr_out, 12);
    nc(); rst = 1'b0; bus.fmt24 = 1'b1;
    wait_n(20);
    chk("post_hr", bus.hr_out, 0);
    chk("post_sec", bus.sec_out, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
- Parametrised successor to the single-alarm clock, for the same board-level timekeeping role.
- Time base is an internal prescaler from the system clock. Time is kept internally in 24 h format and shown in either 12 h or 24 h format.
- Provides NUM_ALARMS independent alarm channels. Each channel has an enable, one-shot triggering, snooze and ring timeout.
- Feeds display and buzzer logic.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..8).
- TICK_DIV, 50000000, clk cycles per second (>=2).
- SNOOZE_MIN, 5, minutes from a snooze to the re-fire (1..59).
- RING_SECS, 60, seconds an alarm stays active before it is auto-dismissed (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- set_sel  in  SEL_W=$clog2(NUM_ALARMS+1)  target of set pulses: 0 = clock, k = alarm k-1; values above NUM_ALARMS are ignored.
- set_hr  in  1  level input; its 0->1 edge increments the target hour.
- set_min  in  1  level input; its 0->1 edge increments the target minute.
- fmt24  in  1  display format: 1 = 24 h, 0 = 12 h.
- alarm_en  in  NUM_ALARMS  per-channel enable.
- snooze  in  NUM_ALARMS  per-channel snooze request, level; sampled each cycle.
- dismiss  in  NUM_ALARMS  per-channel dismiss request, level; sampled each cycle.
- hr_out  out  5  clock hour, formatted per fmt24.
- pm_out  out  1  set when the internal hour is 12..23.
- min_out  out  6  clock minute.
- sec_out  out  6  clock second.
- alm_hr_out  out  5  hour of the selected alarm, formatted (channel set_sel-1; channel 0 when set_sel is 0 or out of range).
- alm_min_out  out  6  minute of the selected alarm.
- alarm_active  out  NUM_ALARMS  per-channel ringing flag, registered.
- alarm_any  out  1  OR of alarm_active, registered.

Behaviour:
- Reset:
  - Time is 00:00:00 and the prescaler is 0.
  - All alarms are 00:00; all active flags, snooze-pending flags and counters are 0.
  - Outputs after reset: hr_out=12 in 12 h mode or 0 in 24 h mode, pm_out=0, alarm_any=0.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - sec_tick is asserted in the cycle the count equals TICK_DIV-1.
- Counting on sec_tick:
  - sec wraps 59->0 and carries to min.
  - min wraps 59->0 and carries to hr.
  - hr wraps 23->0.
- Edge detect:
  - set_hr and set_min are registered once; pulse = input & ~registered.
  - A pulse is one cycle, so set inputs need no synchronizer beyond this (they are board-debounced).
- Clock set (set_sel=0):
  - A minute pulse gives min = (min+1) mod 60 with no carry into hr.
  - An hour pulse gives hr = (hr+1) mod 24.
  - Seconds keep running.
  - If a set pulse and a tick carry hit the same field in the same cycle, the set pulse wins and the carry into that field is dropped. sec still wraps to 0.
- Alarm set (set_sel=k): same increment rules applied to alarm k-1. Time is unaffected.
- Format:
  - 12 h display: internal 0 -> 12, 1..12 -> same, 13..23 -> hr-12.
  - 24 h display: hr shown unchanged.
  - Formatting is combinational from registered hour state.
- Trigger (per channel i):
  - Fires only on the sec_tick whose next time is hh:mm:00 with hh:mm equal to alarm i, and only if alarm_en[i]=1 and alarm i is not already active.
  - alarm_active[i] goes to 1 on the following clock edge.
  - Editing an alarm to the current time does not fire; there is no level compare.
- Snooze (while active[i]=1, snooze[i]=1):
  - active[i] clears and snooze_pend[i] sets; the snooze counter loads SNOOZE_MIN.
  - The counter decrements on each minute rollover.
  - On reaching 0, active[i] sets and snooze_pend[i] clears.
  - A snooze request while inactive is ignored.
- Dismiss: dismiss[i]=1 clears active[i], snooze_pend[i] and the snooze counter. It takes priority over snooze and over a same-cycle trigger.
- Ring timeout:
  - The ring counter resets when active[i] rises and counts sec_ticks.
  - At RING_SECS, active[i] clears (no snooze).
- Disable: alarm_en[i]=0 forces active[i]=0 and snooze_pend[i]=0 on the next edge.
- A regular trigger during snooze_pend re-fires the channel and clears the pending snooze.
- Reset asserted mid-ring or mid-snooze returns everything to reset state immediately.

Decomposition:
- Package alarm_clock_pkg:
  - Constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - Widths HR_W=5, MIN_W=6.
  - Function to_disp_hr(hr, fmt24).
- Sub-module alarm_channel (one per channel, generate loop). It holds:
  - the alarm hr/min registers and set increments;
  - match detection;
  - the active/snooze_pend state;
  - the snooze and ring counters.
- The top level holds the prescaler, time counters, edge detect, readback mux and alarm_any.

Test Plan:
- TICK_DIV=4; release rst; run 4*3600 cycles -> time 01:00:00, hr_out=1, pm_out=0; sec wraps at 59 with no drift.
- Set time 23:59:58 via set_sel=0 edges and fmt24=0 -> after 2 ticks shows 12:00:00 with pm_out=0; at 11:59:59 -> 12:00:00 gives pm_out=1.
- Alarm 2 = 07:30 with en=1; time 07:29:59 -> alarm_active=4'b0100 one cycle after the tick; after 60 s with no input it auto-clears.
- Snooze ch0 at 06:00 (SNOOZE_MIN=5) -> active clears; re-fires at 06:05:00; dismiss+snooze in the same cycle -> dismiss wins, no re-fire at 06:10.
- set_min pulse in the same cycle as a :59 tick on set_sel=0 -> min increments once, sec=0, hr unchanged; set_sel=5 with NUM_ALARMS=4 -> no change anywhere.
- Set alarm 1 to the current time mid-minute -> no fire; alarm_en[1] dropped while ringing -> active clears next edge; rst pulse while ringing -> all outputs at reset values.
